// File: rtl/dsram_responder.sv
// Data-side memory responder: one load/store at a time, byte-enabled word RAM, fixed response latency.
// Optional DSRAM_RAND_DELAY_EN adds an LFSR that extends each request's latency by 0..3 cycles.
module dsram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [3:0]  write_we,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] read_data,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t                state_reg, state_next;
  logic [4:0]            cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]            we_reg;
  logic [31:0]           wdata_reg;
  logic                  accept;
  logic                  fire;
  logic                  fire_ok;
  logic [ADDR_WIDTH-1:0] f_idx;
  logic [3:0]            f_we;
  logic [31:0]           f_wdata;
  logic [31:0]           rd_word;
  logic [4:0]            lat_m1;

`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_reg <= 8'hA5;
    else     lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  assign lat_m1 = 5'(LATENCY - 1) + {3'b000, lfsr_reg[1:0]};
`else
  assign lat_m1 = 5'(LATENCY - 1);
`endif

  // cnt_reg counts BUSY cycles left before the response cycle; the RAM access
  // happens on the edge that enters the response cycle (the accept edge when L=1).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    fire       = 1'b0;
    f_idx      = addr_reg;
    f_we       = we_reg;
    f_wdata    = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (write_en) begin
          accept     = 1'b1;
          state_next = BUSY;
          cnt_next   = lat_m1;
          f_idx      = write_addr[ADDR_WIDTH+1:2];
          f_we       = write_we;
          f_wdata    = write_data;
          fire       = (lat_m1 == 5'd0);
        end
      end
      BUSY: begin
        if (cnt_reg == 5'd0) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg - 5'd1;
          fire     = (cnt_reg == 5'd1);
        end
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM is not reset, so its write strobe must be masked while reset is held.
  assign fire_ok = fire & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 5'd0;
      addr_reg   <= '0;
      we_reg     <= 4'd0;
      wdata_reg  <= 32'd0;
      data_ready <= 1'b0;
      data_valid <= 1'b0;
      read_data  <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      data_ready <= fire && (f_we != 4'd0);
      data_valid <= fire && (f_we == 4'd0);
      if (accept) begin
        addr_reg  <= write_addr[ADDR_WIDTH+1:2];
        we_reg    <= write_we;
        wdata_reg <= write_data;
      end
      if (fire && (f_we == 4'd0)) read_data <= rd_word;
    end
  end

  assign busy = (state_reg != IDLE);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (fire_ok && f_we[gi]) mem[f_idx] <= f_wdata[8*gi +: 8];
    end

    assign rd_word[8*gi +: 8] = mem[f_idx];
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder; define DSRAM_RAND_DELAY_EN to run the random-latency scenario.
module tb_dsram_responder;

`ifdef DSRAM_RAND_DELAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  write_we = 4'd0;
  logic [31:0] write_addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic        data_ready;
  logic        data_valid;
  logic [31:0] read_data;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  dsram_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_we(write_we),
    .write_addr(write_addr), .write_data(write_data), .data_ready(data_ready),
    .data_valid(data_valid), .read_data(read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (idle) cycle T; returns in cycle T+1 with write_en low.
  task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    write_we   = we;
    write_addr = addr;
    write_data = data;
    write_en   = 1'b1;
    step();
    write_en   = 1'b0;
  endtask

  // Full transaction: latency measured to the response pulse, then wait until idle again.
  task automatic xact(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                      output int lat, output logic [31:0] rd, output logic ok);
    int n;
    issue(we, addr, data);
    lat = 1;
    while (!(data_ready || data_valid) && lat < 40) begin
      step();
      lat++;
    end
    ok = (we != 4'd0) ? (data_ready && !data_valid) : (data_valid && !data_ready);
    rd = read_data;
    $display("xact we=%b addr=%h wdata=%h lat=%0d rdata=%h", we, addr, data, lat, rd);
    n = 0;
    step();
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({data_ready, data_valid, busy, read_data} !== 35'd0) begin
      n_mis++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b rd=%h want all 0",
               data_ready, data_valid, busy, read_data);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    int lat;
    logic ok;
    issue(4'b1111, 32'h100, 32'hDEADBEEF);
    n_cmp++;
    if ({data_ready, data_valid, busy} !== 3'b001) begin
      n_mis++;
      $display("FAIL store_t1 got rdy/vld/busy=%b want 001", {data_ready, data_valid, busy});
    end
    step();
    n_cmp++;
    if ({data_ready, data_valid, busy} !== 3'b101) begin
      n_mis++;
      $display("FAIL store_t2 got rdy/vld/busy=%b want 101", {data_ready, data_valid, busy});
    end
    step();
    n_cmp++;
    if ({data_ready, data_valid, busy} !== 3'b001) begin
      n_mis++;
      $display("FAIL store_hold got rdy/vld/busy=%b want 001", {data_ready, data_valid, busy});
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL store_t4_idle got busy=%b want 0", busy);
    end
    $display("xact store addr=00000100 wdata=deadbeef checked cycle by cycle");
    issue(4'b0000, 32'h100, 32'h0);
    n_cmp++;
    if ({data_ready, data_valid} !== 2'b00) begin
      n_mis++;
      $display("FAIL load_t5 got rdy/vld=%b want 00", {data_ready, data_valid});
    end
    step();
    n_cmp++;
    if ({data_ready, data_valid} !== 2'b01 || read_data !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL load_t6 got rdy/vld=%b rd=%h want 01 deadbeef", {data_ready, data_valid}, read_data);
    end
    step();
    step();
    $display("xact load addr=00000100 rdata=%h", read_data);
    // Bit 12 is above the word index and bits 1:0 are below it: both alias word 0x40.
    xact(4'b0000, 32'h0000_1102, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || !ok || lat != LAT) begin
      n_mis++;
      $display("FAIL alias_load got rd=%h ok=%b lat=%0d want deadbeef 1 %0d", rd, ok, lat, LAT);
    end
  endtask

  task automatic test_merge();
    logic [31:0] rd;
    int lat;
    logic ok;
    xact(4'b1111, 32'h40, 32'h11223344, lat, rd, ok);
    xact(4'b0100, 32'h40, 32'hAAAAAAAA, lat, rd, ok);
    xact(4'b0000, 32'h40, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h11AA3344 || !ok) begin
      n_mis++;
      $display("FAIL merge_byte got rd=%h ok=%b want 11aa3344 1", rd, ok);
    end
    xact(4'b0011, 32'h40, 32'h55665566, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h11AA3344 || !ok || lat != LAT) begin
      n_mis++;
      $display("FAIL rd_hold_on_store got rd=%h ok=%b lat=%0d want 11aa3344 1 %0d", rd, ok, lat, LAT);
    end
    xact(4'b0000, 32'h40, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h11AA5566 || !ok) begin
      n_mis++;
      $display("FAIL merge_half got rd=%h ok=%b want 11aa5566 1", rd, ok);
    end
  endtask

  task automatic test_held();
    int pulses = 0;
    int busy_low = 0;
    int lat;
    logic [31:0] rd;
    logic ok;
    write_we   = 4'b0000;
    write_addr = 32'h100;
    write_data = 32'h0;
    write_en   = 1'b1;
    step();
    for (int i = 1; i <= LAT + 1; i++) begin
      if (data_valid) pulses++;
      if (!busy) busy_low++;
      step();
    end
    n_cmp++;
    if (pulses != 1 || busy_low != 0) begin
      n_mis++;
      $display("FAIL held_pulses got pulses=%0d busy_low=%0d want 1 0", pulses, busy_low);
    end
    n_cmp++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL held_idle_gap got busy=%b vld=%b want 0 0", busy, data_valid);
    end
    step();
    write_en = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++;
      $display("FAIL held_reaccept got busy=%b want 1", busy);
    end
    $display("xact held load addr=00000100 pulses=%0d", pulses);
    for (int i = 0; i < LAT + 2; i++) step();
    xact(4'b0000, 32'h100, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || !ok) begin
      n_mis++;
      $display("FAIL held_after got rd=%h ok=%b want deadbeef 1", rd, ok);
    end
  endtask

  task automatic test_midchange();
    int lat = 0;
    int rdy_seen = 0;
    logic [31:0] rd;
    logic ok;
    xact(4'b1111, 32'h200, 32'h12345678, lat, rd, ok);
    issue(4'b0000, 32'h100, 32'h0);
    write_we   = 4'b1111;
    write_addr = 32'h200;
    write_data = 32'hFFFFFFFF;
    write_en   = 1'b1;
    lat = 1;
    while (!data_valid && lat < 40) begin
      if (data_ready) rdy_seen++;
      step();
      lat++;
    end
    write_en = 1'b0;
    n_cmp++;
    if (lat != LAT || read_data !== 32'hDEADBEEF || rdy_seen != 0) begin
      n_mis++;
      $display("FAIL midchange_resp got lat=%0d rd=%h rdy=%0d want %0d deadbeef 0", lat, read_data, rdy_seen, LAT);
    end
    $display("xact midchange load lat=%0d rdata=%h", lat, read_data);
    step();
    step();
    xact(4'b0000, 32'h200, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h12345678 || !ok) begin
      n_mis++;
      $display("FAIL midchange_mem got rd=%h ok=%b want 12345678 1", rd, ok);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    int rdy_seen = 0;
    logic [31:0] rd;
    logic ok;
    xact(4'b1111, 32'h80, 32'h0, lat, rd, ok);
    xact(4'b0000, 32'h100, 32'h0, lat, rd, ok);
    issue(4'b1111, 32'h80, 32'hCAFEF00D);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({data_ready, data_valid, busy, read_data} !== 35'd0) begin
      n_mis++;
      $display("FAIL async_reset_out got rdy=%b vld=%b busy=%b rd=%h want all 0",
               data_ready, data_valid, busy, read_data);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (data_ready || data_valid || busy) rdy_seen++;
      step();
    end
    n_cmp++;
    if (rdy_seen != 0) begin
      n_mis++;
      $display("FAIL async_reset_quiet got active_cycles=%0d want 0", rdy_seen);
    end
    $display("xact store addr=00000080 aborted by reset");
    xact(4'b0000, 32'h80, 32'h0, lat, rd, ok);
    n_cmp++;
    if (rd !== 32'h0 || !ok) begin
      n_mis++;
      $display("FAIL async_reset_mem got rd=%h ok=%b want 00000000 1", rd, ok);
    end
  endtask

  task automatic test_rand_delay();
    logic [3:0] seen = 4'd0;
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    logic ok;
    for (int i = 0; i < 4; i++)
      xact(4'b1111, 32'(i * 4), 32'hA0B0C0D0 + 32'(i), lat, rd, ok);
    for (int i = 0; i < 200; i++) begin
      exp = 32'hA0B0C0D0 + 32'(i % 4);
      xact(4'b0000, 32'((i % 4) * 4), 32'h0, lat, rd, ok);
      n_cmp++;
      if (lat < 1 || lat > 4 || !ok) begin
        n_mis++;
        $display("FAIL rand_lat[%0d] got lat=%0d ok=%b want 1..4 1", i, lat, ok);
      end else begin
        seen[lat-1] = 1'b1;
      end
      n_cmp++;
      if (rd !== exp) begin
        n_mis++;
        $display("FAIL rand_data[%0d] got %h want %h", i, rd, exp);
      end
    end
    n_cmp++;
    if (seen !== 4'hF) begin
      n_mis++;
      $display("FAIL rand_coverage got seen=%b want 1111", seen);
    end
  endtask

  initial begin
    test_reset();
`ifdef DSRAM_RAND_DELAY_EN
    test_rand_delay();
`else
    test_store_load();
    test_merge();
    test_held();
    test_midchange();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dsram_responder.md
# dsram_responder

Data-side memory responder: the slave end of the MEM-stage data request interface. It accepts one load or store at a time, applies per-byte write enables to an internal word-addressed RAM, and answers after a fixed latency: `data_ready` for stores, `data_valid` plus `read_data` for loads. It sits between the CPU core's MEM stage and the data memory in the single-core test SoC. It also serves as a latency model for exercising MEM-stage stall and flush behaviour.

## Interface
- `ADDR_WIDTH`, 10, word-index bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, 2, cycles from request acceptance to response; legal range 1..15.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `write_en`  in  1  request valid, for both load and store.
- `write_we`  in  4  byte enables; any nonzero value marks a store, 4'b0000 marks a load.
- `write_addr`  in  32  byte address; word index is `write_addr[ADDR_WIDTH+1:2]`; higher bits are ignored and alias.
- `write_data`  in  32  store data, already lane-replicated by the requester.
- `data_ready`  out  1  one-cycle pulse: store committed.
- `data_valid`  out  1  one-cycle pulse: load data valid.
- `read_data`  out  32  load result (full word).
- `busy`  out  1  high in BUSY and HOLD states.

## Operation
- **States:** IDLE, BUSY, HOLD. Reset enters IDLE.
- **Accept:**
  - A request is accepted in any IDLE cycle with `write_en`=1.
  - On acceptance, the block latches addr, we and wdata, loads the down-counter with the effective latency, and moves to BUSY.
- **BUSY:**
  - Inputs are ignored. Requester changes, `write_en` drops and flushes do not abort a request already accepted.
  - The requester discards unwanted responses.
- **Response:**
  - The block performs the RAM access at the edge that begins the response cycle.
  - Store: RAM bytes i with `we[i]`=1 take `wdata[8i+7:8i]`; other bytes are unchanged. `data_ready`=1 for exactly that cycle.
  - Load: `read_data` is loaded with the addressed word and `data_valid`=1 for that cycle.
  - The state moves to HOLD.
- **HOLD:**
  - Lasts exactly one cycle. `write_en` is ignored, because the requester may still present the completed request during this cycle.
  - The state then returns to IDLE.
- **Response exclusivity:** `data_ready` and `data_valid` are never high together, and neither is high outside the response cycle.
- **`read_data` hold:** `read_data` keeps its value until the next load response. Store responses do not change it.
- **Read-after-write:** a load accepted after a store's response cycle returns the stored bytes.
- **Reset:**
  - All outputs go to 0, the state goes to IDLE, and the counter is cleared.
  - A reset mid-request aborts it: a pending store is not written and no response is issued.
  - RAM contents are not reset.

## Timing
- Request accepted in cycle T (state IDLE, `write_en`=1).
- Response pulse in cycle T+L, where L is the effective latency. With L=1, the pulse is in T+1.
- HOLD in cycle T+L+1. The earliest next acceptance is T+L+2.
- Maximum throughput is one request per L+2 cycles.
- `busy` is high from T+1 through T+L+1 inclusive.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`DSRAM_RAND_DELAY_EN` defined:**
  - Adds an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset value 8'hA5, advancing every cycle.
  - Effective latency L = LATENCY + lfsr[1:0], sampled at acceptance. Range is LATENCY..LATENCY+3.
  - `busy` and HOLD rules are unchanged.
- **Undefined:** L = LATENCY exactly, and no LFSR logic is present.

## Test plan
- **Store then load:** reset, LATENCY=2. Store we=4'b1111 addr=0x100 data=0xDEADBEEF accepted at T → `data_ready` only in T+2. Load addr=0x100 accepted at T+4 → `data_valid` in T+6 with `read_data`=0xDEADBEEF.
- **Byte and halfword merge:** preload 0x11223344 at 0x40.
  - Store we=4'b0100 data=0xAAAAAAAA → word reads 0x11AA3344.
  - Store we=4'b0011 data=0x55665566 → word reads 0x11AA5566.
- **Held request:** `write_en` held high with the same load through the response cycle and HOLD → exactly one `data_valid` pulse. A second acceptance occurs only at T+L+2.
- **Mid-request change:** at T+1 the requester swaps to a store at 0x200 → ignored. The original load response arrives in T+L and 0x200 is unchanged.
- **Async reset:** assert `rst` mid-cycle at T+1 of a store to 0x80 (old value 0x0) → outputs go to 0 immediately, no `data_ready`, and 0x80 still reads 0x0.
- **Random delay:** with `DSRAM_RAND_DELAY_EN` and LATENCY=1, run 200 loads → every response latency is in 1..4, all four values are observed, and data is always correct.
